// File: rtl/dvbc_qam_mapper_if.sv
// dvbc_qam_mapper stream interface: byte input side and
// symbol output side, each with a valid/ready handshake.
interface dvbc_qam_mapper_if #(
   parameter int BB_SYMBOL_WIDTH = 8
);
   logic [7:0]                        data_i;
   logic                              sync_i;
   logic                              valid_i;
   logic                              ready_o;
   logic signed [BB_SYMBOL_WIDTH-1:0] sym_i_o;
   logic signed [BB_SYMBOL_WIDTH-1:0] sym_q_o;
   logic                              sym_sync_o;
   logic                              sym_valid_o;
   logic                              sym_ready_i;

   modport master (
      output data_i,
      output sync_i,
      output valid_i,
      output sym_ready_i,
      input  ready_o,
      input  sym_i_o,
      input  sym_q_o,
      input  sym_sync_o,
      input  sym_valid_o
   );

   modport slave (
      input  data_i,
      input  sync_i,
      input  valid_i,
      input  sym_ready_i,
      output ready_o,
      output sym_i_o,
      output sym_q_o,
      output sym_sync_o,
      output sym_valid_o
   );
endinterface

// File: rtl/dvbc_qam_mapper.sv
// DVB-C byte-to-symbol converter with differential MSB
// coding and 16/64/256-QAM mapping to signed I/Q.
module dvbc_qam_mapper #(
   parameter int BB_SYMBOL_WIDTH = 8
) (
   input  logic               clk_sys_i,
   input  logic               rst_sys_i,
   input  logic [1:0]         mode_i,
   output logic               err_o,
   dvbc_qam_mapper_if.slave   bus
);
   localparam int W = BB_SYMBOL_WIDTH;

   // held bits are MSB-aligned; bit 14 is the oldest
   logic [14:0]         r_data;
   logic [14:0]         r_mark;
   logic [3:0]          r_cnt;
   logic [1:0]          r_mode;
   logic                r_ip;
   logic                r_qp;
   logic                r_err;
   logic [W-1:0]        r_sym_i;
   logic [W-1:0]        r_sym_q;
   logic                r_sym_sync;
   logic                r_sym_valid;

   logic [7:0]          w_tup;
   logic [7:0]          w_mtup;
   logic [7:0]          w_msk;
   logic [3:0]          w_m;
   logic [3:0]          w_sh;
   logic [2:0]          w_u;
   logic [2:0]          w_v;
   logic [3:0]          w_li;
   logic [3:0]          w_lq;
   logic [W-1:0]        w_x;
   logic [W-1:0]        w_y;
   logic                w_a;
   logic                w_b;
   logic                w_i;
   logic                w_q;
   logic [W-1:0]        w_si;
   logic [W-1:0]        w_sq;
   logic                w_pop;
   logic [3:0]          w_rem;
   logic                w_ready;
   logic                w_acc;
   logic [3:0]          w_base;
   logic [14:0]         w_keep_d;
   logic [14:0]         w_keep_m;
   logic [14:0]         w_ins_d;
   logic [14:0]         w_ins_m;
   logic                w_mode_upd;

   function automatic logic [2:0] f_g2b(input logic [2:0] g);
      return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
   endfunction

   assign w_tup  = r_data[14:7];
   assign w_mtup = r_mark[14:7] & w_msk;

   // per-mode tuple size, amplitude fields and scale shift
   always_comb begin
      w_m   = 4'd4;
      w_msk = 8'hF0;
      w_u   = {2'b00, w_tup[5]};
      w_v   = {2'b00, w_tup[4]};
      w_sh  = 4'(W - 3);
      case (r_mode)
         2'd1: begin
            w_m   = 4'd6;
            w_msk = 8'hFC;
            w_u   = {1'b0, w_tup[5:4]};
            w_v   = {1'b0, w_tup[3:2]};
            w_sh  = 4'(W - 4);
         end
         2'd2: begin
            w_m   = 4'd8;
            w_msk = 8'hFF;
            w_u   = w_tup[5:3];
            w_v   = w_tup[2:0];
            w_sh  = 4'(W - 5);
         end
         default: begin
            w_m   = 4'd4;
            w_msk = 8'hF0;
            w_u   = {2'b00, w_tup[5]};
            w_v   = {2'b00, w_tup[4]};
            w_sh  = 4'(W - 3);
         end
      endcase
   end

   assign w_li = {f_g2b(w_u), 1'b1};
   assign w_lq = {f_g2b(w_v), 1'b1};
   assign w_x  = {{(W-4){1'b0}}, w_li} << w_sh;
   assign w_y  = {{(W-4){1'b0}}, w_lq} << w_sh;

   assign w_a = w_tup[7];
   assign w_b = w_tup[6];
   assign w_i = (w_a ^ w_b) ? (w_a ^ r_qp) : (w_a ^ r_ip);
   assign w_q = (w_a ^ w_b) ? (w_b ^ r_ip) : (w_b ^ r_qp);

   // quadrant rotation of the first-quadrant point
   always_comb begin
      w_si = w_x;
      w_sq = w_y;
      unique case ({w_i, w_q})
         2'b00: begin w_si = w_x;  w_sq = w_y;  end
         2'b10: begin w_si = -w_y; w_sq = w_x;  end
         2'b11: begin w_si = -w_x; w_sq = -w_y; end
         2'b01: begin w_si = w_y;  w_sq = -w_x; end
      endcase
   end

   assign w_pop   = (r_cnt >= w_m) &&
                    (!r_sym_valid || bus.sym_ready_i);
   assign w_rem   = r_cnt - w_m;
   assign w_ready = (r_cnt <= 4'd7) ||
                    (w_pop && (w_rem <= 4'd7));
   assign w_acc   = bus.valid_i && w_ready;
   assign w_base  = w_pop ? w_rem : r_cnt;

   // new byte lands directly below the bits still held
   assign w_keep_d = w_pop ? (r_data << w_m) : r_data;
   assign w_keep_m = w_pop ? (r_mark << w_m) : r_mark;
   assign w_ins_d  = {bus.data_i, 7'd0} >> w_base;
   assign w_ins_m  = {bus.sync_i, 14'd0} >> w_base;

   assign w_mode_upd = (r_cnt == 4'd0) && !w_acc;

   // bit accumulator and sync markers
   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         r_data <= '0;
         r_mark <= '0;
         r_cnt  <= '0;
      end else begin
         r_data <= w_keep_d | (w_acc ? w_ins_d : 15'd0);
         r_mark <= w_keep_m | (w_acc ? w_ins_m : 15'd0);
         r_cnt  <= w_base + (w_acc ? 4'd8 : 4'd0);
      end
   end

   // differential state, mode register and sticky error
   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         r_ip   <= 1'b0;
         r_qp   <= 1'b0;
         r_mode <= 2'd0;
         r_err  <= 1'b0;
      end else begin
         if (w_pop) begin
            r_ip <= w_i;
            r_qp <= w_q;
         end
         if (w_mode_upd) begin
            if (mode_i == 2'd3) begin
               r_err <= 1'b1;
            end else if (mode_i != r_mode) begin
               r_mode <= mode_i;
               r_ip   <= 1'b0;
               r_qp   <= 1'b0;
            end
         end
      end
   end

   // output symbol register, held while stalled
   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         r_sym_i     <= '0;
         r_sym_q     <= '0;
         r_sym_sync  <= 1'b0;
         r_sym_valid <= 1'b0;
      end else if (w_pop) begin
         r_sym_i     <= w_si;
         r_sym_q     <= w_sq;
         r_sym_sync  <= |w_mtup;
         r_sym_valid <= 1'b1;
      end else if (bus.sym_ready_i) begin
         r_sym_valid <= 1'b0;
      end
   end

   assign bus.ready_o     = w_ready;
   assign bus.sym_i_o     = $signed(r_sym_i);
   assign bus.sym_q_o     = $signed(r_sym_q);
   assign bus.sym_sync_o  = r_sym_sync;
   assign bus.sym_valid_o = r_sym_valid;
   assign err_o           = r_err;
endmodule
